// File: rtl/mac_vec_player_pkg.sv
// mac_vec_pkg: shared types for the MAC vector player.
//   vec_t     one stored vector: stimulus (a, b, vin, clr) plus expected response (ev, ef)
//   state_t   player FSM states
//   ERR_MAX   saturation value of the error counter
//   VEC_IDLE  value presented to the MAC whenever no vector is being played
// vec_t field widths are fixed here; the player's IN_WIDTH/OUT_WIDTH must match them.
package mac_vec_pkg;

    localparam int VEC_IN_W  = 10;
    localparam int VEC_OUT_W = 20;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    typedef struct packed {
        logic signed [VEC_IN_W-1:0]  a;
        logic signed [VEC_IN_W-1:0]  b;
        logic                        vin;
        logic                        clr;
        logic                        ev;
        logic signed [VEC_OUT_W-1:0] ef;
    } vec_t;

    // MAC held in reset with no valid input; ev/ef are don't-care here.
    localparam vec_t VEC_IDLE = '{a: '0, b: '0, vin: 1'b0, clr: 1'b1, ev: 1'b0, ef: '0};

endpackage

// File: rtl/mac_vec_player_if.sv
// mac_vec_player_if: connection between the vector player and the MAC under test.
//   a, b, valid_in, reset   player -> MAC stimulus
//   f, valid_out            MAC -> player response
// Modports: master (player side), slave (MAC side).
interface mac_vec_player_if #(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 20
);
    logic signed [IN_WIDTH-1:0]  a;
    logic signed [IN_WIDTH-1:0]  b;
    logic                        valid_in;
    logic                        reset;
    logic signed [OUT_WIDTH-1:0] f;
    logic                        valid_out;

    modport master (output a, b, valid_in, reset, input f, valid_out);
    modport slave  (input a, b, valid_in, reset, output f, valid_out);
endinterface

// File: rtl/mac_vec_player_vec_ram.sv
// vec_ram: DEPTH x W single-port-write / single-port-read memory with a
// registered read (latency 1).
//   clk           clock
//   we/waddr/wdata write port
//   rd_rst        synchronous load of RST_VAL into the read register
//   raddr/rdata   read port; rdata updates every cycle rd_rst is low
// The read register doubles as the player's stimulus output register, which is
// why it has a synchronous preset value. Memory contents are never cleared.
module vec_ram #(
    parameter int             DEPTH   = 1000,
    parameter int             W       = 8,
    parameter int             AW      = $clog2(DEPTH),
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          rd_rst,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rd_rst) rdata <= RST_VAL;
        else        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mac_vec_player.sv
// mac_vec_player: plays a stored list of stimulus vectors into a MAC, one per
// cycle, and compares the MAC response against the stored expectation.
//   clk, reset        clock, synchronous active-high reset
//   ld_*              vector load port (accepted only in IDLE/DONE)
//   start, num_vec    start a run of num_vec vectors (0 -> straight to DONE)
//   mac               master side of mac_vec_player_if (registered stimulus out,
//                     f/valid_out in)
//   busy, done        run status
//   vec_cnt, err_cnt  vectors compared / mismatches (saturating) in this run
// Optional: define MAC_VEC_FIRSTERR_EN to add first_err_idx/first_err_f/
// first_err_vld, capturing the first mismatch of each run.
module mac_vec_player
    import mac_vec_pkg::*;
#(
    parameter int   IN_WIDTH  = VEC_IN_W,
    parameter int   OUT_WIDTH = VEC_OUT_W,
    parameter int   DEPTH     = 1000,
    localparam int  AW        = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ld_we,
    input  logic [AW-1:0]               ld_addr,
    input  logic signed [IN_WIDTH-1:0]  ld_a,
    input  logic signed [IN_WIDTH-1:0]  ld_b,
    input  logic                        ld_vin,
    input  logic                        ld_clr,
    input  logic                        ld_ev,
    input  logic signed [OUT_WIDTH-1:0] ld_ef,
    input  logic                        start,
    input  logic [AW:0]                 num_vec,
    mac_vec_player_if.master            mac,
    output logic                        busy,
    output logic                        done,
    output logic [AW:0]                 vec_cnt,
    output logic [15:0]                 err_cnt
`ifdef MAC_VEC_FIRSTERR_EN
    ,
    output logic [AW-1:0]               first_err_idx,
    output logic signed [OUT_WIDTH-1:0] first_err_f,
    output logic                        first_err_vld
`endif
);

    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] ADR_ONE = 1;

    state_t      state;
    logic [AW:0] nvec_q;
    vec_t        wvec;
    vec_t        cur;
    logic        ram_we;
    logic        rd_rst;
    logic [AW-1:0] raddr;
    logic        last;
    logic        mismatch;

    always_comb begin
        wvec     = VEC_IDLE;
        wvec.a   = ld_a;
        wvec.b   = ld_b;
        wvec.vin = ld_vin;
        wvec.clr = ld_clr;
        wvec.ev  = ld_ev;
        wvec.ef  = ld_ef;
    end

    assign ram_we = ld_we && (state == IDLE || state == DONE);
    assign last   = (vec_cnt == nvec_q - CNT_ONE);

    // Read one entry ahead: PRIME fetches entry 0, RUN cycle k fetches k+1.
    // Whenever nothing is to be played next, the read register is preset to
    // the idle vector so the MAC sits in reset.
    assign raddr  = (state == RUN) ? vec_cnt[AW-1:0] + ADR_ONE : '0;
    assign rd_rst = reset || !(state == PRIME || (state == RUN && !last));

    vec_ram #(
        .DEPTH   (DEPTH),
        .W       ($bits(vec_t)),
        .AW      (AW),
        .RST_VAL (VEC_IDLE)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ld_addr),
        .wdata  (wvec),
        .rd_rst (rd_rst),
        .raddr  (raddr),
        .rdata  (cur)
    );

    // The read register holds vector k for the whole of RUN cycle k, so it
    // drives the MAC and supplies expectation k to the comparator.
    assign mac.a        = cur.a;
    assign mac.b        = cur.b;
    assign mac.valid_in = cur.vin;
    assign mac.reset    = cur.clr;

    // f is only meaningful while the MAC flags it valid.
    assign mismatch = (mac.valid_out != cur.ev) || (mac.valid_out && (mac.f != cur.ef));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            vec_cnt <= '0;
            err_cnt <= '0;
            nvec_q  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec_cnt <= '0;
                        err_cnt <= '0;
                        nvec_q  <= num_vec;
                        if (num_vec == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= PRIME;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                PRIME: begin
                    state   <= RUN;
                    vec_cnt <= '0;
                    err_cnt <= '0;
                end
                RUN: begin
                    vec_cnt <= vec_cnt + CNT_ONE;
                    if (mismatch && err_cnt != ERR_MAX) err_cnt <= err_cnt + 16'd1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAC_VEC_FIRSTERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_f   <= '0;
        end else if (state == PRIME) begin
            first_err_vld <= 1'b0;
        end else if (state == RUN && mismatch && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= vec_cnt[AW-1:0];
            first_err_f   <= mac.f;
        end
    end
`endif

endmodule

// File: tb/tb_mac_vec_player.sv
// Bench for mac_vec_player: a behavioural MAC (1-cycle latency accumulator)
// answers the player; run expectations go into a scoreboard that a monitor
// checks whenever the player reports done.
module tb_mac_vec_player;

    localparam int AW = 10;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                ld_we = 1'b0;
    logic [AW-1:0]       ld_addr = '0;
    logic signed [9:0]   ld_a = '0;
    logic signed [9:0]   ld_b = '0;
    logic                ld_vin = 1'b0;
    logic                ld_clr = 1'b0;
    logic                ld_ev = 1'b0;
    logic signed [19:0]  ld_ef = '0;
    logic                start = 1'b0;
    logic [AW:0]         num_vec = '0;
    logic                busy, done;
    logic [AW:0]         vec_cnt;
    logic [15:0]         err_cnt;
`ifdef MAC_VEC_FIRSTERR_EN
    logic [AW-1:0]       first_err_idx;
    logic signed [19:0]  first_err_f;
    logic                first_err_vld;
`endif

    mac_vec_player_if #(.IN_WIDTH(10), .OUT_WIDTH(20)) mif ();

    mac_vec_player dut (
        .clk     (clk),
        .reset   (reset),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .ld_vin  (ld_vin),
        .ld_clr  (ld_clr),
        .ld_ev   (ld_ev),
        .ld_ef   (ld_ef),
        .start   (start),
        .num_vec (num_vec),
        .mac     (mif),
        .busy    (busy),
        .done    (done),
        .vec_cnt (vec_cnt),
        .err_cnt (err_cnt)
`ifdef MAC_VEC_FIRSTERR_EN
        ,
        .first_err_idx (first_err_idx),
        .first_err_f   (first_err_f),
        .first_err_vld (first_err_vld)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural MAC: registered accumulate, valid_out follows valid_in by one cycle.
    logic signed [19:0] mf;
    logic               mvo;
    int                 vin_cycles = 0;
    always @(posedge clk) begin
        if (mif.reset) begin
            mf  <= '0;
            mvo <= 1'b0;
        end else begin
            mvo <= mif.valid_in;
            if (mif.valid_in) mf <= mf + mif.a * mif.b;
        end
        if (mif.valid_in) vin_cycles <= vin_cycles + 1;
    end
    assign mif.f         = mf;
    assign mif.valid_out = mvo;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int tag;
        int vc;
        int ec;
        bit fv;
        int fi;
    } exp_t;
    exp_t sb[$];

    // Monitor: a run ends when done rises, or when a num_vec=0 start is
    // accepted while already done.
    logic done_d = 1'b0;
    logic st_d   = 1'b0;
    always @(posedge clk) st_d <= start;
    always @(negedge clk) begin
        if (!reset && done && (!done_d || st_d)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done: vec_cnt %0d err_cnt %0d", vec_cnt, err_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("run%0d vec_cnt", e.tag), vec_cnt, e.vc);
                chk($sformatf("run%0d err_cnt", e.tag), err_cnt, e.ec);
`ifdef MAC_VEC_FIRSTERR_EN
                chk($sformatf("run%0d first_err_vld", e.tag), first_err_vld, e.fv);
                if (e.fv) chk($sformatf("run%0d first_err_idx", e.tag), first_err_idx, e.fi);
`endif
            end
        end
        done_d <= done;
    end

    task automatic set_ld(input int addr, input int a, input int b, input bit vin,
                          input bit clr, input bit ev, input int ef);
        ld_addr = AW'(addr);
        ld_a    = 10'(a);
        ld_b    = 10'(b);
        ld_vin  = vin;
        ld_clr  = clr;
        ld_ev   = ev;
        ld_ef   = 20'(ef);
        ld_we   = 1'b1;
    endtask

    task automatic load(input int addr, input int a, input int b, input bit vin,
                        input bit clr, input bit ev, input int ef);
        set_ld(addr, a, b, vin, clr, ev, ef);
        @(posedge clk);
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Starts a run (any pending set_ld write shares the start cycle), waits
    // for done within a cycle budget, and optionally forces err_cnt mid-run.
    task automatic run(input int tag, input int n, input int ec, input bit fv,
                       input int fi, input int force_at);
        exp_t e;
        int   lat;
        e.tag = tag; e.vc = n; e.ec = ec; e.fv = fv; e.fi = fi;
        sb.push_back(e);
        num_vec = (AW+1)'(n);
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ld_we = 1'b0;
        lat   = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (!done) chk($sformatf("run%0d busy", tag), busy, 1);
            if (lat == force_at) begin
                force dut.err_cnt = 16'hFFFD;
                #1 release dut.err_cnt;
            end
        end
        chk($sformatf("run%0d latency", tag), lat, (n == 0) ? 0 : n + 1);
        chk($sformatf("run%0d idle mac_reset", tag), mif.reset, 1);
        chk($sformatf("run%0d idle mac_valid_in", tag), mif.valid_in, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("reset mac_reset", mif.reset, 1);
        chk("reset mac_valid_in", mif.valid_in, 0);
        chk("reset mac_a", mif.a, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset vec_cnt", vec_cnt, 0);
        chk("reset err_cnt", err_cnt, 0);

        // Run 1: correct MAC, expectations hand-computed: f 0, 6, 6-20=-14.
        load(0, 2, 3, 1, 0, 0, 0);
        load(1, -4, 5, 1, 0, 1, 6);
        load(2, 0, 0, 0, 0, 1, -14);
        run(1, 3, 0, 0, 0, -1);

        // Run 2: ef[1] off by one.
        load(1, -4, 5, 1, 0, 1, 7);
        run(2, 3, 1, 1, 1, -1);

        // Run 3: ev[0]=0 with garbage ef[0]; f must be ignored.
        load(1, -4, 5, 1, 0, 1, 6);
        load(0, 2, 3, 1, 0, 0, 12345);
        run(3, 3, 0, 0, 0, -1);

        // Run 4: entry 0 rewritten (ev[0]=1) in the same cycle as start.
        set_ld(0, 2, 3, 1, 0, 1, 0);
        run(4, 3, 1, 1, 0, -1);

        // Run 5: num_vec=0 from DONE zeroes counts, never drives valid_in.
        v0 = vin_cycles;
        run(5, 0, 0, 1, 0, -1);
        chk("run5 valid_in cycles", vin_cycles - v0, 0);

        // Reset during RUN cycle 5 of 10.
        for (int i = 0; i < 10; i++) load(i, i, 1, 1, 0, 0, 0);
        num_vec = 11'd10;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort pre busy", busy, 1);
        chk("abort pre mac_valid_in", mif.valid_in, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort mac_reset", mif.reset, 1);
        chk("abort mac_valid_in", mif.valid_in, 0);
        chk("abort vec_cnt", vec_cnt, 0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Run 6: every vector mismatches; err_cnt forced to FFFD mid-run must stick at FFFF.
        for (int i = 0; i < 6; i++) load(i, 1, 1, 0, 0, 1, 0);
        run(6, 6, 16'hFFFF, 1, 0, 2);

        repeat (2) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
